// File: rtl/debounce_pkg.sv
// Shared widths and edge encoding for the multi-channel debouncer.
package debounce_pkg;

  localparam int DEF_CHANNELS    = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;
  localparam int DEF_DIV_W       = 16;
  localparam int DEF_GLITCH_W    = 8;

  typedef enum logic [1:0] {
    EDGE_NONE,
    EDGE_RISE,
    EDGE_FALL
  } edge_t;

endpackage

// File: rtl/debounce_channel.sv
// One debounce lane: synchroniser, stability counter, edge pulses, glitch counter.
// Everything but the synchroniser advances only on the shared sample tick.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GLITCH_W    = DEF_GLITCH_W,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic [CNT_W-1:0]    thr_eff,
  input  logic                glitch_clear,
  input  logic                din,
  output logic                dout,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_count
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_q, dout_d;
  logic [GLITCH_W-1:0]    glitch_q, glitch_d;
  edge_t                  edge_q, edge_d;
  logic [CNT_W:0]         cnt_inc;
  logic                   s;

  assign s       = sync_q[SYNC_STAGES-1];
  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    sync_d   = sync_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    glitch_d = glitch_q;
    edge_d   = EDGE_NONE;

    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end

    if (tick) begin
      if (s == dout_q) begin
        // A run that collapsed before reaching threshold counts as a glitch.
        if (cnt_q != '0 && glitch_q != '1) begin
          glitch_d = glitch_q + GLITCH_W'(1);
        end
        cnt_d = '0;
      end else if (cnt_inc >= {1'b0, thr_eff}) begin
        dout_d = s;
        cnt_d  = '0;
        edge_d = s ? EDGE_RISE : EDGE_FALL;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end

    if (glitch_clear) begin
      glitch_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q    <= '0;
      dout_q   <= RESET_LEVEL;
      glitch_q <= '0;
      edge_q   <= EDGE_NONE;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      glitch_q <= glitch_d;
      edge_q   <= edge_d;
    end
  end

  assign dout         = dout_q;
  assign rise         = (edge_q == EDGE_RISE);
  assign fall         = (edge_q == EDGE_FALL);
  assign glitch_count = glitch_q;

endmodule

// File: rtl/debounce_filter_array.sv
// Multi-channel debouncer top: shared sample prescaler, threshold clamp, lane array.
// Filtered outputs switch SYNC_STAGES + thr_eff - 1 edges after a captured change when sampling every clk.
module debounce_filter_array
  import debounce_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int GLITCH_W    = DEF_GLITCH_W,
  parameter bit RESET_LEVEL = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DIV_W-1:0]             sample_div,
  input  logic [CNT_W-1:0]             threshold,
  input  logic                         glitch_clear,
  input  logic [CHANNELS-1:0]          data_in,
  output logic [CHANNELS-1:0]          data_out,
  output logic [CHANNELS-1:0]          rise,
  output logic [CHANNELS-1:0]          fall,
  output logic [CHANNELS*GLITCH_W-1:0] glitch_count
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  logic [CNT_W-1:0] thr_eff;

  // >= rather than == so a sample_div lowered below the count ticks at once.
  always_comb begin
    tick      = (div_cnt_q >= sample_div);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
    thr_eff   = (threshold == '0) ? CNT_W'(1) : threshold;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .GLITCH_W    (GLITCH_W),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .thr_eff      (thr_eff),
      .glitch_clear (glitch_clear),
      .din          (data_in[n]),
      .dout         (data_out[n]),
      .rise         (rise[n]),
      .fall         (fall[n]),
      .glitch_count (glitch_count[n*GLITCH_W +: GLITCH_W])
    );
  end

endmodule
